// File: rtl/regfile_2r1w_if.sv
// Bundle of the regfile_2r1w write, read and clear signals.
// The master drives requests and the slave (the register file) returns read data and status.
interface regfile_2r1w_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] writenum;
  logic              write;
  logic [ADDR_W-1:0] readnum_a;
  logic [ADDR_W-1:0] readnum_b;
  logic              rd_en;
  logic              clr;
  logic [DATA_W-1:0] data_out_a;
  logic [DATA_W-1:0] data_out_b;
  logic              rd_valid;
  logic              busy;

  modport master (
    output data_in, writenum, write, readnum_a, readnum_b, rd_en, clr,
    input  data_out_a, data_out_b, rd_valid, busy
  );

  modport slave (
    input  data_in, writenum, write, readnum_a, readnum_b, rd_en, clr,
    output data_out_a, data_out_b, rd_valid, busy
  );
endinterface

// File: rtl/regfile_2r1w.sv
// Register file with one write port, two registered write-first read ports and a clear-all engine.
// Defining REGFILE_ZERO_REG_EN hard-wires entry 0 to zero.
module regfile_2r1w #(
  parameter int                 DATA_W    = 16,
  parameter int                 DEPTH     = 8,
  parameter int                 ADDR_W    = $clog2(DEPTH),
  parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            reset,
  regfile_2r1w_if.slave   bus
);

  typedef enum logic {IDLE, CLEAR} state_e;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] dout_a_q, dout_a_d;
  logic [DATA_W-1:0] dout_b_q, dout_b_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wr_fire;
  logic              rd_fire;

  function automatic logic in_range(logic [ADDR_W-1:0] idx);
    return int'(idx) < DEPTH;
  endfunction

  // The write that lands on the same edge wins, so a read of that index sees data_in.
  function automatic logic [DATA_W-1:0] read_entry(logic [ADDR_W-1:0] idx);
    logic [DATA_W-1:0] val;
    val = '0;
    if (in_range(idx)) begin
      if (wr_fire && idx == bus.writenum) val = bus.data_in;
      else                                val = mem_q[idx];
    end
`ifdef REGFILE_ZERO_REG_EN
    if (idx == '0) val = '0;
`endif
    return val;
  endfunction

`ifdef REGFILE_ZERO_REG_EN
  assign wr_fire = bus.write && !busy_q && !bus.clr && in_range(bus.writenum)
                   && (bus.writenum != '0);
`else
  assign wr_fire = bus.write && !busy_q && !bus.clr && in_range(bus.writenum);
`endif
  assign rd_fire = bus.rd_en && !busy_q;

  // NOTE: every variable gets its hold value first so no path through this block infers a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    mem_d      = mem_q;
    dout_a_d   = dout_a_q;
    dout_b_d   = dout_b_q;
    rd_valid_d = rd_fire;

    if (rd_fire) begin
      dout_a_d = read_entry(bus.readnum_a);
      dout_b_d = read_entry(bus.readnum_b);
    end

    unique case (state_q)
      IDLE: begin
        if (bus.clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      CLEAR: begin
        mem_d[cnt_q] = RESET_VAL;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // wr_fire is never set while clearing, so this cannot collide with the clear write.
    if (wr_fire) mem_d[bus.writenum] = bus.data_in;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      dout_a_q   <= '0;
      dout_b_q   <= '0;
      rd_valid_q <= 1'b0;
      // NOTE: the storage array is reset here because reset must restore every entry to RESET_VAL.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VAL;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      dout_a_q   <= dout_a_d;
      dout_b_q   <= dout_b_d;
      rd_valid_q <= rd_valid_d;
      mem_q      <= mem_d;
    end
  end

  assign bus.data_out_a = dout_a_q;
  assign bus.data_out_b = dout_b_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed testbench for regfile_2r1w: table-driven read/write/bypass vectors plus
// hand-written clear and reset-during-clear sequences.
module tb_regfile_2r1w;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

`ifdef REGFILE_ZERO_REG_EN
  localparam logic [15:0] R0_EXP = 16'h0000;
`else
  localparam logic [15:0] R0_EXP = 16'hFFFF;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  regfile_2r1w_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_2r1w #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  wn;
    logic [15:0] din;
    logic        rd;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic        exp_v;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic wr, input logic [2:0] wn, input logic [15:0] din,
                        input logic rd, input logic [2:0] ra, input logic [2:0] rb,
                        input logic clr);
    bus.write     = wr;
    bus.writenum  = wn;
    bus.data_in   = din;
    bus.rd_en     = rd;
    bus.readnum_a = ra;
    bus.readnum_b = rb;
    bus.clr       = clr;
  endtask

  // Advance one edge and sample just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 3'(DEPTH - 1 - i), 1'b0);
      step();
      check({tag, "_valid"}, bus.rd_valid, 1'b1);
      check({tag, "_a"}, bus.data_out_a, 16'h0000);
      check({tag, "_b"}, bus.data_out_b, 16'h0000);
    end
    set_in(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 1'b0);
  endtask

  initial begin
    int busy_cnt;

    vecs[0] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 3'd7, 1'b1, 16'h0000, 16'h0000};
    vecs[1] = '{1'b1, 3'd2, 16'hABCD, 1'b0, 3'd0, 3'd0, 1'b0, 16'h0000, 16'h0000};
    vecs[2] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 3'd2, 1'b1, 16'hABCD, 16'hABCD};
    vecs[3] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 1'b0, 16'hABCD, 16'hABCD};
    vecs[4] = '{1'b1, 3'd5, 16'h1234, 1'b1, 3'd5, 3'd5, 1'b1, 16'h1234, 16'h1234};
    vecs[5] = '{1'b1, 3'd6, 16'h5555, 1'b1, 3'd6, 3'd2, 1'b1, 16'h5555, 16'hABCD};
    vecs[6] = '{1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 3'd5, 1'b1, R0_EXP,   16'h1234};
    vecs[7] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 3'd6, 1'b1, R0_EXP,   16'h5555};
    vecs[8] = '{1'b1, 3'd3, 16'h0777, 1'b1, 3'd2, 3'd3, 1'b1, 16'hABCD, 16'h0777};

    reset = 1'b1;
    set_in(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 1'b0);
    step();
    step();
    check("reset_busy", bus.busy, 1'b0);
    check("reset_valid", bus.rd_valid, 1'b0);
    check("reset_a", bus.data_out_a, 16'h0000);
    check("reset_b", bus.data_out_b, 16'h0000);
    reset = 1'b0;

    // Basic reads, writes and write-first bypass.
    for (int v = 0; v < 9; v++) begin
      set_in(vecs[v].wr, vecs[v].wn, vecs[v].din, vecs[v].rd, vecs[v].ra, vecs[v].rb, 1'b0);
      step();
      check($sformatf("vec%0d_valid", v), bus.rd_valid, vecs[v].exp_v);
      check($sformatf("vec%0d_a", v), bus.data_out_a, vecs[v].exp_a);
      check($sformatf("vec%0d_b", v), bus.data_out_b, vecs[v].exp_b);
      check($sformatf("vec%0d_busy", v), bus.busy, 1'b0);
    end

    // Fill every entry, then clear with a same-edge read (accepted) and write (dropped).
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, 3'(i), 16'(16'h0011 * i), 1'b0, 3'd0, 3'd0, 1'b0);
      step();
    end
    set_in(1'b1, 3'd4, 16'hDEAD, 1'b1, 3'd3, 3'd7, 1'b1);
    step();
    check("clr_start_busy", bus.busy, 1'b1);
    check("clr_start_valid", bus.rd_valid, 1'b1);
    check("clr_start_a", bus.data_out_a, 16'h0033);
    check("clr_start_b", bus.data_out_b, 16'h0077);

    // Keep hammering writes to R1, reads and clr while busy; all must be ignored.
    set_in(1'b1, 3'd1, 16'hBEEF, 1'b1, 3'd1, 3'd1, 1'b1);
    busy_cnt = 1;
    for (int c = 0; c < 20 && bus.busy; c++) begin
      step();
      check("clr_busy_valid", bus.rd_valid, 1'b0);
      check("clr_busy_hold_a", bus.data_out_a, 16'h0033);
      check("clr_busy_hold_b", bus.data_out_b, 16'h0077);
      if (bus.busy) busy_cnt++;
    end
    check("clr_busy_cycles", busy_cnt, DEPTH);
    check("clr_done_busy", bus.busy, 1'b0);
    read_all_zero("post_clr");

    // Reset arriving three cycles into a clear.
    set_in(1'b1, 3'd5, 16'h1234, 1'b0, 3'd0, 3'd0, 1'b0);
    step();
    set_in(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 3'd5, 1'b0);
    step();
    check("pre_rst_a", bus.data_out_a, 16'h1234);
    set_in(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 1'b1);
    step();
    set_in(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 1'b0);
    step();
    step();
    step();
    check("mid_clr_busy", bus.busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_busy", bus.busy, 1'b0);
    check("async_rst_a", bus.data_out_a, 16'h0000);
    check("async_rst_b", bus.data_out_b, 16'h0000);
    check("async_rst_valid", bus.rd_valid, 1'b0);
    step();
    reset = 1'b0;
    step();
    step();
    check("post_rst_idle_busy", bus.busy, 1'b0);
    read_all_zero("post_rst");
    check("post_rst_final_busy", bus.busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
